// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_ACK, WAIT_DONE} arb_state_t;

  localparam int NUM_REQ_MAX = 8;

  // Index that follows ptr, wrapping back to zero at n.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 32'sd1 >= n) ? 32'sd0 : ptr + 32'sd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or after ptr_i, circularly.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_valid_o
);

  localparam int PW = $clog2(2 * N);

  logic [2*N-1:0] dbl_s;
  logic [PW-1:0]  pos_s;

  assign dbl_s = {req_i, req_i};

  // Walk from the farthest slot back to ptr so the nearest requester overwrites last.
  always_comb begin
    idx_o       = {IDX_W{1'b0}};
    any_valid_o = 1'b0;
    pos_s       = {PW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      pos_s       = PW'(ptr_i) + PW'(k);
      idx_o       = dbl_s[pos_s] ? IDX_W'(int'(pos_s) % N) : idx_o;
      any_valid_o = any_valid_o | dbl_s[pos_s];
    end
    grant_o = any_valid_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : {N{1'b0}};
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ word sources, one word in flight.
// Optional burst lock (req_lock port) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                grant_active_q, grant_active_d;

  logic [NUM_REQ-1:0]  pick_onehot_s, sel_onehot_s;
  logic [IDX_W-1:0]    pick_idx_s, sel_idx_s;
  logic                any_valid_s, lock_hit_s, can_grant_s;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (pick_onehot_s),
    .idx_o       (pick_idx_s),
    .any_valid_o (any_valid_s)
  );

`ifdef UART_ARB_LOCK_EN
  assign lock_hit_s = req_lock[grant_id_q] & req_valid[grant_id_q];
`else
  assign lock_hit_s = 1'b0;
`endif

  // A busy uart_tx is never ready, even if it claims ready (another master may own it).
  assign sel_idx_s    = lock_hit_s ? grant_id_q : pick_idx_s;
  assign sel_onehot_s = lock_hit_s ? (ONE_HOT0 << grant_id_q) : pick_onehot_s;
  assign can_grant_s  = (state_q == ARB) & tx_ready & ~tx_busy & (any_valid_s | lock_hit_s);
  assign req_ready    = can_grant_s ? sel_onehot_s : {NUM_REQ{1'b0}};

  // Next-state and datapath decisions for the grant/issue/wait sequence.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = 1'b0;
    grant_active_d = grant_active_q;
    case (state_q)
      ARB: begin
        if (can_grant_s) begin
          state_d        = ISSUE;
          tx_data_d      = req_data[sel_idx_s*DATA_W +: DATA_W];
          grant_id_d     = sel_idx_s;
          rr_ptr_d       = lock_hit_s ? rr_ptr_q : IDX_W'(rr_next(int'(sel_idx_s), NUM_REQ));
          tx_valid_d     = 1'b1;
          grant_active_d = 1'b1;
        end else begin
          state_d = ARB;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy && tx_ready) begin
          state_d        = ARB;
          grant_active_d = 1'b0;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d        = ARB;
        grant_active_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB;
      rr_ptr_q       <= {IDX_W{1'b0}};
      grant_id_q     <= {IDX_W{1'b0}};
      tx_data_q      <= {DATA_W{1'b0}};
      tx_valid_q     <= 1'b0;
      grant_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      grant_active_q <= grant_active_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx handshake model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int FRAME   = 160;  // 4 bytes x 10 bits x 4 ticks per bit

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_lock = '0;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid, tx_ready, tx_busy, grant_active;
  logic [1:0]                grant_id;
  logic                      ready_block = 1'b0, stray_busy = 1'b0;
  int                        frame_cnt;

  int   n_checks = 0, n_errors = 0, cyc = 0, n_rdy = 0, last_rdy_cyc = 0, c0;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] held;
  logic        held_v = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
`ifdef UART_ARB_LOCK_EN
    .req_lock     (req_lock),
`endif
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: busy for one frame after sampling data_valid.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= 0;
    else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
    else if (tx_valid) frame_cnt <= FRAME;
  end
  assign tx_busy  = (frame_cnt != 0) || stray_busy;
  assign tx_ready = (frame_cnt == 0) && !ready_block;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id);
    exp_t x;
    x.id   = id;
    x.data = req_data[id*DATA_W +: DATA_W];
    exp_q.push_back(x);
  endtask

  task automatic wait_grants(input int n);
    int tgt;
    tgt = n_rdy + n;
    for (int i = 0; i < 3000 && n_rdy < tgt; i++) @(negedge clk);
    check_eq("grant_seen", 64'(n_rdy >= tgt), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !grant_active && !tx_busy) break;
      @(negedge clk);
    end
    check_eq("drain", 64'(exp_q.size() == 0 && !grant_active), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("rst_tx_data", 64'(tx_data), 64'd0);
    check_eq("rst_grant_id", 64'(grant_id), 64'd0);
    check_eq("rst_grant_active", 64'(grant_active), 64'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: match grants and issued words against the expectation queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (grant_active) check_eq("rdy_while_busy", 64'(req_ready), 64'd0);
      if (req_ready != '0) begin
        check_eq("rdy_onehot", 64'($onehot(req_ready)), 64'd1);
        check_eq("rdy_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check_eq("rdy_id", 64'(req_ready), 64'd1 << exp_q[0].id);
        last_rdy_cyc = cyc;
        n_rdy++;
      end
      if (tx_valid) begin
        check_eq("valid_latency", 64'(cyc - last_rdy_cyc), 64'd1);
        check_eq("valid_while_busy", 64'(tx_busy), 64'd0);
        check_eq("word_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("tx_data", 64'(tx_data), 64'(e.data));
          check_eq("grant_id", 64'(grant_id), 64'(e.id));
        end
        held   = tx_data;
        held_v = 1'b1;
      end else if (held_v && tx_busy) begin
        check_eq("data_hold", 64'(tx_data), 64'(held));
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'h1000_0000 * i;
    #2;
    reset_dut();

    // Single request from requester 2.
    req_data[2*DATA_W +: DATA_W] = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    push_exp(2);
    req_valid = 4'b0100;
    wait_grants(1);
    req_valid = 4'b0000;
    drain();
    check_eq("single_grant_id", 64'(grant_id), 64'd2);
    req_data[2*DATA_W +: DATA_W] = 32'h2000_0000;

    // All four requesting from a fresh pointer: 0,1,2,3,0.
    @(negedge clk);
    reset_dut();
    @(posedge clk); #1;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    req_valid = 4'b1111;
    wait_grants(5);
    req_valid = 4'b0000;
    drain();

    // Pointer wrap: grant 3, then 1001 gives 0 before 3.
    push_exp(3);
    req_valid = 4'b1000;
    wait_grants(1);
    push_exp(0); push_exp(3);
    req_valid = 4'b1001;
    wait_grants(2);
    req_valid = 4'b0000;
    drain();

    // Back-pressure: requester 1 waits through a frame, granted on first ready ARB cycle.
    push_exp(0);
    req_valid = 4'b0001;
    wait_grants(1);
    push_exp(1);
    req_valid = 4'b0010;
    for (int i = 0; i < 300 && !tx_busy; i++) @(negedge clk);
    for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk);
    c0 = cyc;
    wait_grants(1);
    req_valid = 4'b0000;
    check_eq("first_ready_grant", 64'(last_rdy_cyc - c0), 64'd1);
    drain();

    // Idle ARB with tx_ready low, then with a stray busy: no grant either way.
    @(posedge clk); #1;
    ready_block = 1'b1;
    req_valid   = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      check_eq("arb_not_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    ready_block = 1'b0;
    stray_busy  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("arb_stray_busy", 64'(req_ready), 64'd0);
    end
    push_exp(2);
    @(posedge clk); #1;
    stray_busy = 1'b0;
    wait_grants(1);
    req_valid = 4'b0000;
    drain();

    // Reset in WAIT_DONE: word dropped, requester 0 first afterwards.
    push_exp(1);
    req_valid = 4'b0010;
    wait_grants(1);
    req_valid = 4'b0000;
    for (int i = 0; i < 300 && !tx_busy; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check_eq("pre_reset_active", 64'(grant_active), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    req_valid = 4'b0101;
    push_exp(0); push_exp(2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_grants(2);
    req_valid = 4'b0000;
    drain();

`ifdef UART_ARB_LOCK_EN
    // Burst lock on requester 1, then plain round-robin resumes at 0.
    push_exp(0); push_exp(1);
    req_valid = 4'b0011;
    wait_grants(2);
    req_lock = 4'b0010;
    push_exp(1); push_exp(1);
    wait_grants(2);
    req_lock = 4'b0000;
    push_exp(0);
    wait_grants(1);
    req_valid = 4'b0000;
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
